// File: rtl/branch_predictor_unit_if.sv
// Predictor bundle: ID-stage prediction request/response, EX-stage
// resolution, flush/redirect and statistics outputs.
interface branch_predictor_unit_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 3,
  parameter int STAT_BITS  = 16
);
  logic                  id_branch;
  logic [PC_WIDTH-1:0]   id_pc;
  logic                  predict_taken;
  logic [INDEX_BITS-1:0] predict_index;
  logic                  ex_branch;
  logic [INDEX_BITS-1:0] ex_index;
  logic                  ex_pred_taken;
  logic                  ex_taken;
  logic [PC_WIDTH-1:0]   ex_pc;
  logic [PC_WIDTH-1:0]   ex_target;
  logic                  flush;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic [STAT_BITS-1:0]  branch_count;
  logic [STAT_BITS-1:0]  mispredict_count;

  modport master (
    output id_branch, id_pc,
    output ex_branch, ex_index, ex_pred_taken,
    output ex_taken, ex_pc, ex_target,
    input  predict_taken, predict_index,
    input  flush, redirect_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  id_branch, id_pc,
    input  ex_branch, ex_index, ex_pred_taken,
    input  ex_taken, ex_pc, ex_target,
    output predict_taken, predict_index,
    output flush, redirect_pc,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_unit.sv
// PHT branch predictor (bimodal or gshare): ID prediction, EX update,
// flush/redirect on mispredict, saturating stats. Ports: clock, reset, bp.
module branch_predictor_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 3,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int INIT_CTR   = (1 << CTR_BITS) - 1,
  parameter int STAT_BITS  = 16
) (
  input logic clock,
  input logic reset,
  branch_predictor_unit_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT =
    CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0]   pht [ENTRIES];
  logic [INDEX_BITS-1:0] ghr_pad;
  logic [INDEX_BITS-1:0] idx;
  logic [STAT_BITS-1:0]  br_cnt;
  logic [STAT_BITS-1:0]  mp_cnt;
  logic                  flush;
  logic                  unused_pc;

  if (GHR_BITS > 0) begin : g_ghr
    logic [GHR_BITS-1:0] ghr;
    // History is shifted only by resolved branches (non-speculative).
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)
        ghr <= '0;
      else if (bp.ex_branch)
        ghr <= GHR_BITS'({ghr, bp.ex_taken});
    end
    assign ghr_pad = INDEX_BITS'(ghr);
  end else begin : g_bimodal
    assign ghr_pad = '0;
  end

  assign idx = bp.id_pc[INDEX_BITS+1:2] ^ ghr_pad;
  assign unused_pc = ^bp.id_pc;

  assign flush = reset & bp.ex_branch &
                 (bp.ex_pred_taken != bp.ex_taken);

  always_comb begin
    bp.redirect_pc = '0;
    if (flush)
      bp.redirect_pc = bp.ex_taken ? bp.ex_target
                     : bp.ex_pc + PC_WIDTH'(4);
  end

  // A same-cycle flush squashes the ID instruction.
  assign bp.predict_taken = reset & bp.id_branch &
                            pht[idx][CTR_BITS-1] & ~flush;
  assign bp.predict_index = bp.id_branch ? idx : '0;
  assign bp.flush = flush;
  assign bp.branch_count = br_cnt;
  assign bp.mispredict_count = mp_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++)
        pht[i] <= CTR_INIT;
    end else if (bp.ex_branch) begin
      if (bp.ex_taken) begin
        if (pht[bp.ex_index] != CTR_MAX)
          pht[bp.ex_index] <=
            pht[bp.ex_index] + CTR_BITS'(1);
      end else if (pht[bp.ex_index] != '0) begin
        pht[bp.ex_index] <=
          pht[bp.ex_index] - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (bp.ex_branch) begin
      if (br_cnt != '1)
        br_cnt <= br_cnt + STAT_BITS'(1);
      if (flush && mp_cnt != '1)
        mp_cnt <= mp_cnt + STAT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed-vector bench for branch_predictor_unit: default bimodal,
// gshare (GHR_BITS=2) and narrow-stats (STAT_BITS=2) instances.
module tb_branch_predictor_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  branch_predictor_unit_if if0 ();
  branch_predictor_unit_if #(.STAT_BITS(16)) if1 ();
  branch_predictor_unit_if #(.STAT_BITS(2))  if2 ();

  branch_predictor_unit dut0 (
    .clock(clock), .reset(reset), .bp(if0.slave)
  );
  branch_predictor_unit #(.GHR_BITS(2)) dut1 (
    .clock(clock), .reset(reset), .bp(if1.slave)
  );
  branch_predictor_unit #(.STAT_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .bp(if2.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic ex0(input logic br, input logic [2:0] ix,
                     input logic pt, input logic tk,
                     input logic [31:0] pc,
                     input logic [31:0] tg);
    if0.ex_branch = br;
    if0.ex_index = ix;
    if0.ex_pred_taken = pt;
    if0.ex_taken = tk;
    if0.ex_pc = pc;
    if0.ex_target = tg;
  endtask

  int         ctr [8];
  logic [1:0] mghr;
  logic [2:0] midx;
  logic       mpred;
  logic       mtk;

  initial begin
    if0.id_branch = 1'b1;
    if0.id_pc = 32'h10;
    ex0(1'b1, 3'd4, 1'b1, 1'b0, 32'h10, 32'h40);
    if1.id_branch = 1'b0; if1.id_pc = '0;
    if1.ex_branch = 1'b0; if1.ex_index = '0;
    if1.ex_pred_taken = 1'b0; if1.ex_taken = 1'b0;
    if1.ex_pc = '0; if1.ex_target = '0;
    if2.id_branch = 1'b0; if2.id_pc = '0;
    if2.ex_branch = 1'b0; if2.ex_index = '0;
    if2.ex_pred_taken = 1'b0; if2.ex_taken = 1'b0;
    if2.ex_pc = '0; if2.ex_target = '0;

    #2;
    chk("rst_pt", 32'(if0.predict_taken), 0);
    chk("rst_flush", 32'(if0.flush), 0);
    chk("rst_redir", if0.redirect_pc, 0);
    chk("rst_bc", 32'(if0.branch_count), 0);
    chk("rst_mc", 32'(if0.mispredict_count), 0);
    ex0(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    #1;
    chk("init_pt", 32'(if0.predict_taken), 1);
    chk("init_pi", 32'(if0.predict_index), 4);
    chk("init_bc", 32'(if0.branch_count), 0);

    // three not-taken resolves at idx 4: 3->2->1->0
    ex0(1'b1, 3'd4, 1'b1, 1'b0, 32'h10, 32'h40);
    #1;
    chk("nt1_flush", 32'(if0.flush), 1);
    chk("nt1_redir", if0.redirect_pc, 32'h14);
    chk("nt1_pt_sq", 32'(if0.predict_taken), 0);
    tick();
    ex0(1'b0, 3'd4, 1'b1, 1'b0, 32'h10, 32'h40);
    #1;
    chk("nt1_after", 32'(if0.predict_taken), 1);
    ex0(1'b1, 3'd4, 1'b1, 1'b0, 32'h10, 32'h40);
    #1;
    chk("nt2_flush", 32'(if0.flush), 1);
    chk("nt2_redir", if0.redirect_pc, 32'h14);
    tick();
    ex0(1'b1, 3'd4, 1'b0, 1'b0, 32'h10, 32'h40);
    #1;
    chk("nt3_pt", 32'(if0.predict_taken), 0);
    chk("nt3_flush", 32'(if0.flush), 0);
    chk("nt3_redir", if0.redirect_pc, 0);
    tick();
    ex0(1'b0, 3'd4, 1'b0, 1'b0, 32'h10, 32'h40);
    #1;
    chk("nt_bc", 32'(if0.branch_count), 3);
    chk("nt_mc", 32'(if0.mispredict_count), 2);

    // two taken resolves with pred 0: 0->1->2
    ex0(1'b1, 3'd4, 1'b0, 1'b1, 32'h10, 32'h40);
    #1;
    chk("t1_flush", 32'(if0.flush), 1);
    chk("t1_redir", if0.redirect_pc, 32'h40);
    tick();
    ex0(1'b0, 3'd4, 1'b0, 1'b1, 32'h10, 32'h40);
    #1;
    chk("t1_pt", 32'(if0.predict_taken), 0);
    ex0(1'b1, 3'd4, 1'b0, 1'b1, 32'h10, 32'h40);
    tick();
    ex0(1'b0, 3'd4, 1'b0, 1'b1, 32'h10, 32'h40);
    #1;
    chk("t2_pt", 32'(if0.predict_taken), 1);
    chk("t2_bc", 32'(if0.branch_count), 5);
    chk("t2_mc", 32'(if0.mispredict_count), 4);

    // 2->3, saturate at 3, then one NT must leave 2
    ex0(1'b1, 3'd4, 1'b1, 1'b1, 32'h10, 32'h40);
    #1;
    chk("t3_flush", 32'(if0.flush), 0);
    tick();
    tick();
    ex0(1'b1, 3'd4, 1'b1, 1'b0, 32'h10, 32'h40);
    tick();
    ex0(1'b0, 3'd4, 1'b0, 1'b0, 32'h10, 32'h40);
    #1;
    chk("sat_pt", 32'(if0.predict_taken), 1);
    chk("sat_bc", 32'(if0.branch_count), 8);
    chk("sat_mc", 32'(if0.mispredict_count), 5);

    // idx 5: 3->2, then same-cycle read/update 2->1
    ex0(1'b1, 3'd5, 1'b0, 1'b0, 32'h14, 32'h40);
    tick();
    if0.id_pc = 32'h14;
    #1;
    chk("rw_pi", 32'(if0.predict_index), 5);
    chk("rw_old", 32'(if0.predict_taken), 1);
    tick();
    ex0(1'b0, 3'd5, 1'b0, 1'b0, 32'h14, 32'h40);
    #1;
    chk("rw_new", 32'(if0.predict_taken), 0);

    // concurrent flush at idx 6, PC wraps on +4
    if0.id_pc = 32'h10;
    ex0(1'b1, 3'd6, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h40);
    #1;
    chk("cf_flush", 32'(if0.flush), 1);
    chk("cf_pt", 32'(if0.predict_taken), 0);
    chk("wrap_redir", if0.redirect_pc, 0);
    tick();
    ex0(1'b0, 3'd6, 1'b1, 1'b0, 32'h18, 32'h40);
    #1;
    chk("nobr_flush", 32'(if0.flush), 0);
    chk("nobr_redir", if0.redirect_pc, 0);
    tick();
    chk("nobr_bc", 32'(if0.branch_count), 11);
    chk("nobr_mc", 32'(if0.mispredict_count), 6);

    // asynchronous reset mid-cycle
    if0.id_pc = 32'h14;
    #1;
    chk("pre_rst_pt", 32'(if0.predict_taken), 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_bc", 32'(if0.branch_count), 0);
    chk("mid_rst_mc", 32'(if0.mispredict_count), 0);
    reset = 1'b1;
    #1;
    chk("post_rst_pt", 32'(if0.predict_taken), 1);
    ex0(1'b1, 3'd5, 1'b1, 1'b0, 32'h14, 32'h40);
    tick();
    ex0(1'b0, 3'd5, 1'b0, 1'b0, 32'h14, 32'h40);
    #1;
    chk("rel_bc", 32'(if0.branch_count), 1);
    chk("rel_mc", 32'(if0.mispredict_count), 1);
    if0.id_branch = 1'b0;
    #1;
    chk("nobr_pi", 32'(if0.predict_index), 0);

    // gshare: alternating T/N at PC 0x10
    for (int i = 0; i < 8; i++) ctr[i] = 3;
    mghr = 2'b00;
    for (int k = 0; k < 10; k++) begin
      mtk = (k % 2 == 0);
      midx = 3'd4 ^ {1'b0, mghr};
      mpred = (ctr[midx] >= 2);
      if1.id_branch = 1'b1;
      if1.id_pc = 32'h10;
      if1.ex_branch = 1'b1;
      if1.ex_index = midx;
      if1.ex_pred_taken = mpred;
      if1.ex_taken = mtk;
      if1.ex_pc = 32'h10;
      if1.ex_target = 32'h40;
      #1;
      chk($sformatf("gs_pi%0d", k),
          32'(if1.predict_index), 32'(midx));
      chk($sformatf("gs_pt%0d", k),
          32'(if1.predict_taken),
          32'(mpred && (mpred == mtk)));
      tick();
      if (mtk && ctr[midx] < 3) ctr[midx]++;
      if (!mtk && ctr[midx] > 0) ctr[midx]--;
      mghr = {mghr[0], mtk};
    end
    if1.ex_branch = 1'b0;
    #1;
    chk("gs_bc", 32'(if1.branch_count), 10);
    chk("gs_mc", 32'(if1.mispredict_count), 2);

    // 2-bit statistics saturate at 3
    for (int k = 0; k < 5; k++) begin
      if2.ex_branch = 1'b1;
      if2.ex_pred_taken = 1'b1;
      if2.ex_taken = 1'b0;
      tick();
      chk($sformatf("st_bc%0d", k),
          32'(if2.branch_count), (k < 3) ? k + 1 : 3);
    end
    if2.ex_branch = 1'b0;
    #1;
    chk("st_mc", 32'(if2.mispredict_count), 3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
